// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// The optional early-out path is enabled by defining MUL_EARLY_OUT_EN.
package mul_seq_pkg;

  typedef enum logic [1:0] {
    MUL_FREE = 2'b00,
    MUL_ON   = 2'b01,
    MUL_END  = 2'b10
  } mul_state_e;

  localparam logic [4:0] MUL_LAST_CNT = 5'd31;

  // Unsigned magnitude; 0x8000_0000 maps onto itself, which is still correct
  // when the value is read back as a 32-bit unsigned number.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mul_seq.sv
// Iterative 32x32 -> 64 multiplier on the execute-stage start/ready handshake.
// Build option: MUL_EARLY_OUT_EN stops iterating once the remaining multiplier is zero.
//
// state    | meaning
// ---------+----------------------------------------------------------
// MUL_FREE | idle, waiting for start_i without annul_i
// MUL_ON   | one shift-add step per cycle on the latched magnitudes
// MUL_END  | product presented with ready_o until start_i drops or annul_i
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_mul_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  mul_state_e  state;
  logic [4:0]  cnt;
  logic [63:0] mcand;
  logic [31:0] mpr;
  logic [63:0] acc;
  logic        neg;

  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [63:0] acc_step;
  logic [31:0] mpr_shift;
  logic        last_step;

  always_comb begin
    mag1      = mag32(opdata1_i, signed_mul_i);
    mag2      = mag32(opdata2_i, signed_mul_i);
    acc_step  = mpr[0] ? (acc + mcand) : acc;
    mpr_shift = mpr >> 1;
    last_step = (cnt == MUL_LAST_CNT);
`ifdef MUL_EARLY_OUT_EN
    if (mpr_shift == 32'd0) last_step = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MUL_FREE;
      cnt      <= 5'd0;
      mcand    <= 64'd0;
      mpr      <= 32'd0;
      acc      <= 64'd0;
      neg      <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        MUL_FREE: begin
          if (start_i && !annul_i) begin
            mcand <= {32'd0, mag1};
            mpr   <= mag2;
            neg   <= (opdata1_i[31] ^ opdata2_i[31]) & signed_mul_i;
            acc   <= 64'd0;
            cnt   <= 5'd0;
            state <= MUL_ON;
`ifdef MUL_EARLY_OUT_EN
            if (mag1 == 32'd0 || mag2 == 32'd0) begin
              state    <= MUL_END;
              result_o <= 64'd0;
              ready_o  <= 1'b1;
            end
`endif
          end
        end

        MUL_ON: begin
          if (annul_i) begin
            acc   <= 64'd0;
            cnt   <= 5'd0;
            state <= MUL_FREE;
          end else begin
            acc   <= acc_step;
            mcand <= mcand << 1;
            mpr   <= mpr_shift;
            cnt   <= cnt + 5'd1;
            if (last_step) begin
              // Product is registered on the final step so END drives it directly.
              state    <= MUL_END;
              result_o <= neg ? (64'd0 - acc_step) : acc_step;
              ready_o  <= 1'b1;
            end
          end
        end

        MUL_END: begin
          if (!start_i || annul_i) begin
            state    <= MUL_FREE;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
          end
        end

        default: begin
          state    <= MUL_FREE;
          result_o <= 64'd0;
          ready_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
